fetch_seq: RTL
==============

// Module: fetch_seq
// PURPOSE
//  Instruction fetch sequencer for the program memory (Psize-bit address, Isize+1-bit word).
//  Owns the program counter, drives the memory address, registers the returned word into a
//  one-entry output slot with a valid/ready handshake to the decoder.
//  Handles absolute/relative branch redirects, halt and restart.
//  Sits between prog memory and the decode/execute stage of the processor core.
// PARAMETERS
//  Psize  6   program address width; PC wraps modulo 2**Psize
//  Isize  24  instruction width is Isize+1 bits (matches program memory word)
// PORTS
//  clk          in   1        system clock, rising edge
//  nReset       in   1        asynchronous reset, active low
//  start        in   1        pulse: leave IDLE/HALT and begin fetching
//  halt         in   1        pulse: stop fetching, enter HALT
//  address      out  Psize    program memory address (= pc, combinational)
//  I            in   Isize+1  word returned by program memory for address (same cycle)
//  instr        out  Isize+1  registered instruction in output slot
//  instr_pc     out  Psize    address instr was fetched from
//  instr_valid  out  1        output slot holds a valid instruction
//  instr_ready  in   1        decoder accepts instr this cycle
//  br_abs       in   1        redirect: pc <= br_target
//  br_rel       in   1        redirect: pc <= instr_pc + br_target (two's complement)
//  br_target    in   Psize    absolute address or signed relative offset
//  running      out  1        state == RUN
//  fault        out  1        sticky wrap fault (WRAP_TRAP_EN only, else 0)
// BEHAVIOUR
//  - Reset (async, nReset=0): state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, fault=0.
//  - States: IDLE -start-> RUN; RUN -halt-> HALT; HALT -start-> RUN. start ignored in RUN.
//  - IDLE/HALT: no fetch, instr_valid forced 0 on entry, pc held.
//  - RUN, slot free (!instr_valid || instr_ready), no redirect: instr<=I, instr_pc<=pc,
//    instr_valid<=1, pc<=pc+1 mod 2**Psize. Latency: address->instr_valid one cycle.
//  - RUN, slot full and !instr_ready: pc, instr, instr_pc, instr_valid all hold.
//  - Redirect (br_abs|br_rel in RUN): decoder asserts it in the cycle it accepts the branch
//    held in the slot. pc<=target, instr_valid<=0 (squash, one-cycle bubble), no fetch.
//    br_abs has priority over br_rel. Relative sum computed in Psize bits, wraps silently.
//  - Redirect ignored outside RUN.
//  - halt with redirect same cycle: halt wins for state, pc still takes redirect target;
//    restart resumes at target. halt has priority over fetch.
//  - start and halt same cycle in HALT/IDLE: halt wins, stay put.
//  - Reset mid-fetch: all state cleared immediately, no partial update.
// CONFIGURATION
//  WRAP_TRAP_EN defined: a sequential increment from pc=2**Psize-1 does not fetch;
//    state->HALT, fault<=1, instr_valid<=0, pc held at 2**Psize-1. fault clears on start.
//    Redirects to any address (including wrapping rel sums) never trap.
//  WRAP_TRAP_EN undefined: pc wraps 2**Psize-1 -> 0 and fetching continues; fault tied 0.
// TESTING
//  1 Reset then start, instr_ready=1, memory word k = k: instr_valid rises 1 cycle after
//    start, instr/instr_pc = 0,1,2,... one per cycle.
//  2 Backpressure: instr_ready=0 for 3 cycles with instr_pc=5 -> instr, pc hold, pc stays 6;
//    ready=1 -> instr_pc=6 next.
//  3 Branch: br_rel with br_target=6'h3E (-2) at instr_pc=10 -> one bubble, next instr_pc=8;
//    br_abs+br_rel with br_target=20 -> next instr_pc=20.
//  4 halt with br_abs target 33 same cycle -> running=0, instr_valid=0; start -> instr_pc=33.
//  5 Wrap at pc=63: without macro next instr_pc=0; with WRAP_TRAP_EN fault=1, running=0,
//    no valid instr; start clears fault.
//  6 nReset low mid-RUN at pc=17 -> immediately pc=0, instr_valid=0, state IDLE.

Source files
------------

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : Instruction fetch sequencer. Owns the PC, drives the program
//            memory address and registers the returned word into a one-entry
//            valid/ready slot. Optional macro WRAP_TRAP_EN traps sequential
//            PC wrap into HALT with a sticky fault.
// Revision : 1.0  initial release
// ============================================================================
module fetch_seq #(
  parameter int Psize = 6,
  parameter int Isize = 24
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             halt,
  output logic [Psize-1:0] address,
  input  logic [Isize:0]   I,
  output logic [Isize:0]   instr,
  output logic [Psize-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             br_abs,
  input  logic             br_rel,
  input  logic [Psize-1:0] br_target,
  output logic             running,
  output logic             fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic [Psize-1:0] instr_pc_q, instr_pc_d;
  logic [Isize:0]   instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fault_q, fault_d;

  logic             redirect;
  logic             slot_free;
  logic             at_top;
  logic [Psize-1:0] br_dest;

`ifdef WRAP_TRAP_EN
  localparam logic [Psize-1:0] PC_MAX = '1;
  assign at_top = (pc_q == PC_MAX);
`else
  assign at_top = 1'b0;
`endif

  assign redirect  = br_abs | br_rel;
  // Relative branches are taken from the PC of the instruction in the slot.
  assign br_dest   = br_abs ? br_target : (instr_pc_q + br_target);
  assign slot_free = !instr_valid_q || instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;

    case (state_q)
      S_RUN: begin
        if (halt) begin
          state_d       = S_HALT;
          instr_valid_d = 1'b0;
          if (redirect) pc_d = br_dest;
        end else if (redirect) begin
          pc_d          = br_dest;
          instr_valid_d = 1'b0;
        end else if (slot_free) begin
          if (at_top) begin
            state_d       = S_HALT;
            fault_d       = 1'b1;
            instr_valid_d = 1'b0;
          end else begin
            instr_d       = I;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 1'b1;
          end
        end
      end
      default: begin
        instr_valid_d = 1'b0;
        if (start && !halt) begin
          state_d = S_RUN;
          fault_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign address     = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign running     = (state_q == S_RUN);
  assign fault       = fault_q;

endmodule
`default_nettype wire
